// File: rtl/usb_pkg.sv
// usb_pkg: shared constants and types for the USB token receive path.
//   - 4-bit PID codes for the token PIDs (OUT, IN, SOF, SETUP)
//   - CRC5 seed, polynomial and good-packet residual
//   - token decoder FSM state type and token_err reason codes
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SOF   = 4'b0101;
  localparam logic [3:0] PID_SETUP = 4'b1101;

  localparam logic [4:0] CRC5_INIT     = 5'b11111;
  localparam logic [4:0] CRC5_POLY     = 5'b00101;
  localparam logic [4:0] CRC5_RESIDUAL = 5'b01100;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PID      = 3'd1,
    ST_BYTE1    = 3'd2,
    ST_BYTE2    = 3'd3,
    ST_WAIT_EOP = 3'd4,
    ST_DISCARD  = 3'd5
  } tok_state_t;

  typedef enum logic [1:0] {
    ERR_NONE = 2'b00,
    ERR_PID  = 2'b01,
    ERR_CRC  = 2'b10,
    ERR_LEN  = 2'b11
  } tok_err_t;

  function automatic logic is_token_pid(input logic [3:0] pid);
    return (pid == PID_OUT) || (pid == PID_IN) ||
           (pid == PID_SOF) || (pid == PID_SETUP);
  endfunction

endpackage

// File: rtl/crc5_byte_step.sv
// crc5_byte_step: combinational CRC5 advance by one byte.
// Bits are consumed LSB first, matching USB wire order.
// Ports:
//   i_crc  [4:0]  current CRC5 register
//   i_data [7:0]  byte to fold in
//   o_crc  [4:0]  CRC5 register after all eight bits
module crc5_byte_step
  import usb_pkg::*;
(
  input  logic [4:0] i_crc,
  input  logic [7:0] i_data,
  output logic [4:0] o_crc
);

  always_comb begin
    logic [4:0] w_c;
    logic       w_fb;
    w_c  = i_crc;
    w_fb = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w_fb = i_data[k] ^ w_c[4];
      w_c  = {w_c[3:0], 1'b0} ^ (w_fb ? CRC5_POLY : 5'b00000);
    end
    o_crc = w_c;
  end

endmodule

// File: rtl/rcv_token_decode.sv
// rcv_token_decode: decodes USB token packets (OUT/IN/SOF/SETUP) from the
// byte stream of the receiver, checks PID and CRC5, and reports the token
// fields or a rejection reason one cycle after end-of-packet.
//
// Build option: define TOKEN_ADDR_FILTER_EN to drop non-SOF tokens whose
// address differs from dev_addr. Without it dev_addr is ignored.
//
// Ports:
//   clk, n_rst              clock, synchronous active-low reset
//   rcv_data[7:0]           received byte, qualified by byte_valid
//   byte_valid, eop         single-cycle strobes from the receiver
//   rcv_abort               receiver error, abandons the packet silently
//   dev_addr[6:0]           device address (filter build only)
//   token_pid/addr/endp     fields of the last accepted token
//   token_valid, token_err  one-cycle result pulses
//   err_code[1:0]           rejection reason alongside token_err
//
// state     | meaning
// IDLE      | waiting for a PID byte
// PID       | token PID accepted, waiting for field byte 1
// BYTE1     | field byte 1 held, waiting for field byte 2
// BYTE2     | not entered; decodes like BYTE1 on eop, returns to IDLE on bytes
// WAIT_EOP  | 16-bit field complete, waiting for eop
// DISCARD   | packet rejected or not a token, waiting for eop
module rcv_token_decode
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] rcv_data,
  input  logic       byte_valid,
  input  logic       eop,
  input  logic       rcv_abort,
  input  logic [6:0] dev_addr,
  output logic [3:0] token_pid,
  output logic [6:0] token_addr,
  output logic [3:0] token_endp,
  output logic       token_valid,
  output logic       token_err,
  output logic [1:0] err_code
);

  tok_state_t r_state;
  logic [4:0] r_crc;
  logic [3:0] r_pid;
  logic [7:0] r_byte1;
  logic [2:0] r_endp_hi;
  tok_err_t   r_code;

  logic [3:0] r_token_pid;
  logic [6:0] r_token_addr;
  logic [3:0] r_token_endp;
  logic       r_token_valid;
  logic       r_token_err;
  logic [1:0] r_err_code;

  logic [4:0] w_crc_step;

  crc5_byte_step u_crc5 (
    .i_crc  (r_crc),
    .i_data (rcv_data),
    .o_crc  (w_crc_step)
  );

  // Stage 1: effect of byte_valid on the current state.
  tok_state_t w_st_b;
  logic [4:0] w_crc_b;
  logic [3:0] w_pid_b;
  logic [7:0] w_b1_b;
  logic [2:0] w_endp_hi_b;
  tok_err_t   w_code_b;
  logic       w_pid_ok;

  assign w_pid_ok = (rcv_data[7:4] == ~rcv_data[3:0]);

  always_comb begin
    w_st_b      = r_state;
    w_crc_b     = r_crc;
    w_pid_b     = r_pid;
    w_b1_b      = r_byte1;
    w_endp_hi_b = r_endp_hi;
    w_code_b    = r_code;
    if (byte_valid) begin
      case (r_state)
        ST_IDLE: begin
          w_crc_b = CRC5_INIT;
          if (!w_pid_ok) begin
            w_st_b   = ST_DISCARD;
            w_code_b = ERR_PID;
          end else if (!is_token_pid(rcv_data[3:0])) begin
            w_st_b   = ST_DISCARD;
            w_code_b = ERR_NONE;
          end else begin
            w_st_b   = ST_PID;
            w_pid_b  = rcv_data[3:0];
            w_code_b = ERR_NONE;
          end
        end
        ST_PID: begin
          w_st_b  = ST_BYTE1;
          w_b1_b  = rcv_data;
          w_crc_b = w_crc_step;
        end
        ST_BYTE1: begin
          w_st_b      = ST_WAIT_EOP;
          w_endp_hi_b = rcv_data[2:0];
          w_crc_b     = w_crc_step;
        end
        ST_WAIT_EOP: begin
          w_st_b   = ST_DISCARD;
          w_code_b = ERR_LEN;
        end
        ST_DISCARD: ;
        default: w_st_b = ST_IDLE;
      endcase
    end
  end

  // Address filter on the field as it stands after this cycle's byte.
  logic w_accept;
`ifdef TOKEN_ADDR_FILTER_EN
  assign w_accept = (w_pid_b == PID_SOF) || (w_b1_b[6:0] == dev_addr);
`else
  logic w_unused_dev_addr;
  assign w_unused_dev_addr = ^dev_addr;
  assign w_accept = 1'b1;
`endif

  // Stage 2: eop applied to the state that stage 1 produced.
  tok_state_t w_st_n;
  logic       w_valid_n;
  logic       w_err_n;
  logic [1:0] w_code_n;

  always_comb begin
    w_st_n    = w_st_b;
    w_valid_n = 1'b0;
    w_err_n   = 1'b0;
    w_code_n  = ERR_NONE;
    if (eop) begin
      case (w_st_b)
        ST_PID, ST_BYTE1, ST_BYTE2: begin
          w_st_n   = ST_IDLE;
          w_err_n  = 1'b1;
          w_code_n = ERR_LEN;
        end
        ST_WAIT_EOP: begin
          w_st_n = ST_IDLE;
          if (w_crc_b != CRC5_RESIDUAL) begin
            w_err_n  = 1'b1;
            w_code_n = ERR_CRC;
          end else if (w_accept) begin
            w_valid_n = 1'b1;
          end
        end
        ST_DISCARD: begin
          w_st_n = ST_IDLE;
          if (w_code_b != ERR_NONE) begin
            w_err_n  = 1'b1;
            w_code_n = w_code_b;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state       <= ST_IDLE;
      r_crc         <= CRC5_INIT;
      r_pid         <= 4'd0;
      r_byte1       <= 8'd0;
      r_endp_hi     <= 3'd0;
      r_code        <= ERR_NONE;
      r_token_pid   <= 4'd0;
      r_token_addr  <= 7'd0;
      r_token_endp  <= 4'd0;
      r_token_valid <= 1'b0;
      r_token_err   <= 1'b0;
      r_err_code    <= 2'b00;
    end else if (rcv_abort) begin
      r_state       <= ST_IDLE;
      r_crc         <= CRC5_INIT;
      r_code        <= ERR_NONE;
      r_token_valid <= 1'b0;
      r_token_err   <= 1'b0;
      r_err_code    <= 2'b00;
    end else begin
      r_state       <= w_st_n;
      r_crc         <= (w_st_n == ST_IDLE) ? CRC5_INIT : w_crc_b;
      r_pid         <= w_pid_b;
      r_byte1       <= w_b1_b;
      r_endp_hi     <= w_endp_hi_b;
      r_code        <= (w_st_n == ST_IDLE) ? ERR_NONE : w_code_b;
      r_token_valid <= w_valid_n;
      r_token_err   <= w_err_n;
      r_err_code    <= w_code_n;
      if (w_valid_n) begin
        r_token_pid  <= w_pid_b;
        r_token_addr <= w_b1_b[6:0];
        r_token_endp <= {w_endp_hi_b, w_b1_b[7]};
      end
    end
  end

  assign token_pid   = r_token_pid;
  assign token_addr  = r_token_addr;
  assign token_endp  = r_token_endp;
  assign token_valid = r_token_valid;
  assign token_err   = r_token_err;
  assign err_code    = r_err_code;

endmodule
